// File: rtl/aes_word_io_if.sv
// Word-stream bundle for aes_word_io: key/plaintext words in, ciphertext words out.
// The block itself uses the slave view; whatever feeds and drains it uses master.
interface aes_word_io_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_key;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   modport master (
      output s_valid, s_data, s_key, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  s_valid, s_data, s_key, m_ready,
      output s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/aes_word_io.sv
// Word-serial front/back end around a 128-bit AES-128 core: gathers key and plaintext
// words, launches the core once, streams the ciphertext out. Define AES_IO_KEY_REUSE_EN to let a block skip key loading.
module aes_word_io (
   input  logic          CLK,
   input  logic          RST,
   aes_word_io_if.slave  io,
   output logic          busy,
   output logic [127:0]  aes_key,
   output logic [127:0]  aes_di,
   output logic          aes_start,
   input  logic [127:0]  aes_do,
   input  logic          aes_done
);

   typedef enum logic [2:0] {
      LOAD_KEY,
      LOAD_DATA,
      START,
      WAIT,
      UNLOAD
   } state_t;

   state_t       state;
   logic [1:0]   wcnt;
   logic [127:0] key_reg;
   logic [127:0] di_reg;
   logic [95:0]  out_reg;
   logic         s_fire;
   logic         m_fire;
   logic         skip_key;

   assign s_fire  = io.s_valid && io.s_ready;
   assign m_fire  = io.m_valid && io.m_ready;
   assign aes_key = key_reg;
   assign aes_di  = di_reg;

`ifdef AES_IO_KEY_REUSE_EN
   // A first word flagged as data jumps straight into the data phase and keeps key_reg.
   assign skip_key = (wcnt == 2'd0) && !io.s_key;
`else
   logic unused_s_key;
   assign skip_key     = 1'b0;
   assign unused_s_key = io.s_key;
`endif

   // Words shift in and out MSW first, so word 0 ends up in / comes from [127:96].
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= LOAD_KEY;
         wcnt       <= 2'd0;
         key_reg    <= '0;
         di_reg     <= '0;
         out_reg    <= '0;
         io.s_ready <= 1'b0;
         io.m_valid <= 1'b0;
         io.m_data  <= '0;
         io.m_last  <= 1'b0;
         busy       <= 1'b0;
         aes_start  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch below sees the pre-edge wcnt/state.
         aes_start <= 1'b0;
         case (state)
            LOAD_KEY: begin
               io.s_ready <= 1'b1;
               if (s_fire) begin
                  busy <= 1'b1;
                  if (skip_key) begin
                     di_reg <= {di_reg[95:0], io.s_data};
                     wcnt   <= 2'd1;
                     state  <= LOAD_DATA;
                  end else begin
                     key_reg <= {key_reg[95:0], io.s_data};
                     wcnt    <= wcnt + 2'd1;
                     if (wcnt == 2'd3) state <= LOAD_DATA;
                  end
               end
            end

            LOAD_DATA: begin
               if (s_fire) begin
                  di_reg <= {di_reg[95:0], io.s_data};
                  wcnt   <= wcnt + 2'd1;
                  if (wcnt == 2'd3) begin
                     io.s_ready <= 1'b0;
                     aes_start  <= 1'b1;
                     state      <= START;
                  end
               end
            end

            START: begin
               state <= WAIT;
            end

            WAIT: begin
               if (aes_done) begin
                  out_reg    <= aes_do[95:0];
                  io.m_data  <= aes_do[127:96];
                  io.m_valid <= 1'b1;
                  io.m_last  <= 1'b0;
                  state      <= UNLOAD;
               end
            end

            UNLOAD: begin
               if (m_fire) begin
                  wcnt <= wcnt + 2'd1;
                  if (wcnt == 2'd3) begin
                     io.m_valid <= 1'b0;
                     io.m_last  <= 1'b0;
                     io.s_ready <= 1'b1;
                     busy       <= 1'b0;
                     state      <= LOAD_KEY;
                  end else begin
                     io.m_data <= out_reg[95:64];
                     out_reg   <= {out_reg[63:0], 32'd0};
                     io.m_last <= (wcnt == 2'd2);
                  end
               end
            end

            default: state <= LOAD_KEY;
         endcase
      end
   end

endmodule

// File: doc/aes_word_io.md
# aes_word_io

32-bit word-serial front/back end for the 128-bit AES-128 encryption core. It gathers key and plaintext words from a valid/ready stream and assembles them into 128-bit vectors. It then launches one encryption on the core, captures the 128-bit ciphertext when the core signals done, and streams it out as four 32-bit words. It sits directly around the core: upstream it drives the core's key, data-in and start; downstream it consumes the core's data-out and done.

## Interface
Parameters: none.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset. Asynchronous, active-high. Also fans out to the core.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept an input word this cycle.
- s_data  in  32  input word.
- s_key  in  1  word is a key word. Used only when AES_IO_KEY_REUSE_EN is defined; ignored otherwise.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  32  ciphertext word.
- m_last  out  1  high with the 4th ciphertext word.
- busy  out  1  high from the first accepted word until the last output word is accepted.
- aes_key  out  128  key to the core.
- aes_di  out  128  plaintext to the core.
- aes_start  out  1  one-cycle start pulse to the core.
- aes_do  in  128  ciphertext from the core.
- aes_done  in  1  one-cycle completion pulse from the core.

## Operation
- A transfer occurs on a cycle with valid && ready.
- Word order is MSW first on both sides: word 0 maps to [127:96] and word 3 maps to [31:0].
- States:
  - LOAD_KEY: accepts 4 key words into key_reg.
  - LOAD_DATA: accepts 4 words into di_reg.
  - START: aes_start=1 for exactly 1 cycle.
  - WAIT: waits for aes_done.
  - UNLOAD: drives 4 words out.
- A 2-bit word counter `wcnt` indexes words in the LOAD and UNLOAD states. It wraps 3→0 on the state transition.
- Transitions:
  - LOAD_KEY → LOAD_DATA on the 4th key transfer.
  - LOAD_DATA → START on the 4th data transfer.
  - START → WAIT unconditionally.
  - WAIT → UNLOAD on aes_done; aes_do is captured into out_reg on that edge.
  - UNLOAD → LOAD_KEY on the 4th output transfer.
- s_ready=1 only in LOAD_KEY and LOAD_DATA.
- m_valid=1 only in UNLOAD.
- aes_key and aes_di are driven from key_reg and di_reg. They are held stable from START until the next block's loading begins.
- No overlap: a new block is not accepted until UNLOAD completes.
- aes_done outside WAIT is ignored.
- m_data and m_last hold stable while m_valid && !m_ready.
- Reset mid-operation clears all state regardless of phase. A partially loaded block is discarded and any pending output is lost.

## Timing
- Reset values:
  - s_ready=0 during reset; rises to 1 on the first CLK edge after RST deasserts (state LOAD_KEY).
  - m_valid=0, m_data=0, m_last=0, busy=0, aes_start=0.
  - aes_key=0, aes_di=0, wcnt=0.
- Back-to-back input transfers are supported at 1 word/cycle. A minimum block load is 8 cycles (4 cycles with key reuse).
- aes_start pulses in the cycle immediately after the 4th data transfer.
- The first output word is valid the cycle after aes_done.
- With m_ready held high, output takes 4 cycles.
- Core latency is not assumed; WAIT is unbounded.
- Throughput = 8 load cycles + 1 start cycle + core latency + 1 cycle + 4 unload cycles.

## Configuration
- AES_IO_KEY_REUSE_EN defined:
  - In LOAD_KEY, a first word with s_key=0 skips key loading. The word is taken as data word 0, the state moves to LOAD_DATA with wcnt=1, and key_reg is retained from the previous block.
  - A first word with s_key=1 loads a new key normally.
  - s_key on words 1–3 of each phase is ignored.
  - After reset with no key ever loaded, reuse encrypts with key 0.
- AES_IO_KEY_REUSE_EN undefined: s_key is ignored, and every block requires 4 key words followed by 4 data words.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 00010203 04050607 08090a0b 0c0d0e0f, then pt 00112233 44556677 8899aabb ccddeeff, with m_ready=1.
  - Required response: m_data 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; m_last on the 4th word; exactly one aes_start pulse.
- FIPS-197 App. B:
  - Stimulus: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, pt 3243f6a8 885a308d 313198a2 e0370734, with s_valid randomly deasserted.
  - Required response: 3925841d 02dc09fb dc118597 196a0b32.
- Output backpressure: m_ready low for 5 cycles on word 2 → m_data holds d8cdb780, and s_ready stays 0 until the 4th word is accepted.
- Reset mid-load: assert RST after 3 data words, then send the full C.1 block → correct C.1 ciphertext and no spurious aes_start.
- Spurious done: pulse aes_done during LOAD_DATA → ignored, and the state sequence is unchanged.
- Key reuse (AES_IO_KEY_REUSE_EN): run C.1, then send 4 data words with s_key=0 equal to the C.1 pt → 69c4e0d8… repeated, with only 4 input transfers for the second block.
